// File: rtl/rf_wb_if.sv
// Writeback request/response bundle between the two requesters and the register-file arbiter.
// Forwarding lookup signals exist only when RF_WB_BYPASS_EN is defined.
interface rf_wb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [AW-1:0]     a_addr;
  logic [XLEN-1:0]   a_data;
  logic              b_valid;
  logic              b_ready;
  logic [AW-1:0]     b_addr;
  logic [XLEN-1:0]   b_data;
  logic              reg_wr;
  logic [AW-1:0]     wr_addr;
  logic [XLEN-1:0]   wr_data;
  logic [2**AW-1:0]  pend_mask;
`ifdef RF_WB_BYPASS_EN
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              rs1_fwd_hit;
  logic              rs2_fwd_hit;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic [XLEN-1:0]   rs2_fwd_data;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, rs1_addr, rs2_addr,
    input  a_ready, b_ready, reg_wr, wr_addr, wr_data, pend_mask,
           rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, rs1_addr, rs2_addr,
    output a_ready, b_ready, reg_wr, wr_addr, wr_data, pend_mask,
           rs1_fwd_hit, rs2_fwd_hit, rs1_fwd_data, rs2_fwd_data
  );
`else
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, reg_wr, wr_addr, wr_data, pend_mask
  );
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, reg_wr, wr_addr, wr_data, pend_mask
  );
`endif
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester writeback arbiter onto the single register-file write port, oldest-first.
// Optional operand forwarding from held slots is enabled with RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input logic  clk,
  input logic  rst,
  rf_wb_if.slave wb
);
  localparam int NREG = 2**AW;

  logic              slot_a_full_q, slot_a_full_d;
  logic [AW-1:0]     slot_a_addr_q, slot_a_addr_d;
  logic [XLEN-1:0]   slot_a_data_q, slot_a_data_d;
  logic              slot_b_full_q, slot_b_full_d;
  logic [AW-1:0]     slot_b_addr_q, slot_b_addr_d;
  logic [XLEN-1:0]   slot_b_data_q, slot_b_data_d;
  logic              older_b_q, older_b_d;
  logic              reg_wr_q, reg_wr_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;

  logic              a_ready_s, b_ready_s;
  logic              keep_a_s, keep_b_s;
  logic              gnt_a_s, gnt_b_s;
  logic [NREG-1:0]   pend_s;

  // Handshake, x0 filtering and grant selection from pre-edge slot state
  always_comb begin
    a_ready_s = rst & ~slot_a_full_q;
    b_ready_s = rst & ~slot_b_full_q;
    keep_a_s  = wb.a_valid & a_ready_s & (wb.a_addr != {AW{1'b0}});
    keep_b_s  = wb.b_valid & b_ready_s & (wb.b_addr != {AW{1'b0}});
    if (slot_a_full_q && slot_b_full_q) begin
      gnt_a_s = ~older_b_q;
      gnt_b_s = older_b_q;
    end else begin
      gnt_a_s = slot_a_full_q;
      gnt_b_s = slot_b_full_q;
    end
  end

  // Slot, age and write-port next state; a slot is only refilled while empty, so never on its grant edge
  always_comb begin
    slot_a_addr_d = slot_a_addr_q;
    slot_a_data_d = slot_a_data_q;
    slot_b_addr_d = slot_b_addr_q;
    slot_b_data_d = slot_b_data_q;
    if (keep_a_s) begin
      slot_a_full_d = 1'b1;
      slot_a_addr_d = wb.a_addr;
      slot_a_data_d = wb.a_data;
    end else if (gnt_a_s) begin
      slot_a_full_d = 1'b0;
    end else begin
      slot_a_full_d = slot_a_full_q;
    end
    if (keep_b_s) begin
      slot_b_full_d = 1'b1;
      slot_b_addr_d = wb.b_addr;
      slot_b_data_d = wb.b_data;
    end else if (gnt_b_s) begin
      slot_b_full_d = 1'b0;
    end else begin
      slot_b_full_d = slot_b_full_q;
    end
    if (keep_a_s && keep_b_s) begin
      older_b_d = 1'b0;
    end else if (keep_a_s && slot_b_full_q) begin
      older_b_d = 1'b1;
    end else if (keep_b_s && slot_a_full_q) begin
      older_b_d = 1'b0;
    end else begin
      older_b_d = older_b_q;
    end
    if (gnt_a_s) begin
      reg_wr_d  = 1'b1;
      wr_addr_d = slot_a_addr_q;
      wr_data_d = slot_a_data_q;
    end else if (gnt_b_s) begin
      reg_wr_d  = 1'b1;
      wr_addr_d = slot_b_addr_q;
      wr_data_d = slot_b_data_q;
    end else begin
      reg_wr_d  = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      slot_a_full_q <= 1'b0;
      slot_a_addr_q <= {AW{1'b0}};
      slot_a_data_q <= {XLEN{1'b0}};
      slot_b_full_q <= 1'b0;
      slot_b_addr_q <= {AW{1'b0}};
      slot_b_data_q <= {XLEN{1'b0}};
      older_b_q     <= 1'b0;
      reg_wr_q      <= 1'b0;
      wr_addr_q     <= {AW{1'b0}};
      wr_data_q     <= {XLEN{1'b0}};
    end else begin
      slot_a_full_q <= slot_a_full_d;
      slot_a_addr_q <= slot_a_addr_d;
      slot_a_data_q <= slot_a_data_d;
      slot_b_full_q <= slot_b_full_d;
      slot_b_addr_q <= slot_b_addr_d;
      slot_b_data_q <= slot_b_data_d;
      older_b_q     <= older_b_d;
      reg_wr_q      <= reg_wr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  // Pending-write mask for hazard stalls, forced clear while in reset
  always_comb begin
    pend_s = {NREG{1'b0}};
    if (rst) begin
      if (slot_a_full_q) begin
        pend_s = pend_s | ({{(NREG-1){1'b0}}, 1'b1} << slot_a_addr_q);
      end else begin
        pend_s = pend_s;
      end
      if (slot_b_full_q) begin
        pend_s = pend_s | ({{(NREG-1){1'b0}}, 1'b1} << slot_b_addr_q);
      end else begin
        pend_s = pend_s;
      end
    end else begin
      pend_s = {NREG{1'b0}};
    end
  end

  assign wb.a_ready   = a_ready_s;
  assign wb.b_ready   = b_ready_s;
  assign wb.reg_wr    = reg_wr_q;
  assign wb.wr_addr   = wr_addr_q;
  assign wb.wr_data   = wr_data_q;
  assign wb.pend_mask = pend_s;

`ifdef RF_WB_BYPASS_EN
  // Returns {hit, data}; when both slots match, the younger slot holds the final value
  function automatic logic [XLEN:0] fwd_lookup(
    input logic [AW-1:0]   ra,
    input logic            fa,
    input logic [AW-1:0]   aa,
    input logic [XLEN-1:0] da,
    input logic            fb,
    input logic [AW-1:0]   ab,
    input logic [XLEN-1:0] db,
    input logic            older_b
  );
    logic hit_a;
    logic hit_b;
    hit_a = fa && (aa == ra) && (ra != {AW{1'b0}});
    hit_b = fb && (ab == ra) && (ra != {AW{1'b0}});
    if (hit_a && hit_b) begin
      fwd_lookup = older_b ? {1'b1, da} : {1'b1, db};
    end else if (hit_a) begin
      fwd_lookup = {1'b1, da};
    end else if (hit_b) begin
      fwd_lookup = {1'b1, db};
    end else begin
      fwd_lookup = {(XLEN+1){1'b0}};
    end
  endfunction

  logic [XLEN:0] rs1_lk_s, rs2_lk_s;

  // Forwarding lookups against the held slots
  always_comb begin
    rs1_lk_s = fwd_lookup(wb.rs1_addr, slot_a_full_q, slot_a_addr_q, slot_a_data_q,
                          slot_b_full_q, slot_b_addr_q, slot_b_data_q, older_b_q);
    rs2_lk_s = fwd_lookup(wb.rs2_addr, slot_a_full_q, slot_a_addr_q, slot_a_data_q,
                          slot_b_full_q, slot_b_addr_q, slot_b_data_q, older_b_q);
  end

  assign wb.rs1_fwd_hit  = rs1_lk_s[XLEN];
  assign wb.rs1_fwd_data = rs1_lk_s[XLEN-1:0];
  assign wb.rs2_fwd_hit  = rs2_lk_s[XLEN];
  assign wb.rs2_fwd_data = rs2_lk_s[XLEN-1:0];
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, collision, age, x0 drop, streaming.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rf_wb_if #(.XLEN(32), .AW(5)) wb ();

  rf_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int          na;
  int          nb;
  int          run;
  int          max_run;
  int          retired;
  int          prev_src;
  logic        acc_a;
  logic        acc_b;
  logic [31:0] expq[$];
  logic [31:0] exp_word;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
`ifdef RF_WB_BYPASS_EN
    wb.rs1_addr = 5'd0;
    wb.rs2_addr = 5'd0;
`endif
    wb.a_valid = 1'b1; wb.a_addr = 5'd3; wb.a_data = 32'h0000_0033;
    wb.b_valid = 1'b1; wb.b_addr = 5'd4; wb.b_data = 32'h0000_0044;

    // Reset held three cycles with both requesters pushing
    tick(); tick(); tick();
    check("rst_a_ready", 64'(wb.a_ready), 64'd0);
    check("rst_b_ready", 64'(wb.b_ready), 64'd0);
    check("rst_reg_wr", 64'(wb.reg_wr), 64'd0);
    check("rst_pend", 64'(wb.pend_mask), 64'd0);
    check("rst_wr_addr", 64'(wb.wr_addr), 64'd0);
    check("rst_wr_data", 64'(wb.wr_data), 64'd0);
    rst = 1'b1;
    wb.a_valid = 1'b0;
    wb.b_valid = 1'b0;
    #1;
    check("rel_a_ready", 64'(wb.a_ready), 64'd1);
    check("rel_b_ready", 64'(wb.b_ready), 64'd1);
    tick();
    check("rel_reg_wr", 64'(wb.reg_wr), 64'd0);

    // Single write from A
    wb.a_valid = 1'b1; wb.a_addr = 5'd10; wb.a_data = 32'h0000_0006;
    tick();
    wb.a_valid = 1'b0;
    check("sw_pend_n", 64'(wb.pend_mask), 64'h0000_0400);
    check("sw_regwr_n", 64'(wb.reg_wr), 64'd0);
    check("sw_a_ready_n", 64'(wb.a_ready), 64'd0);
    tick();
    check("sw_regwr_n1", 64'(wb.reg_wr), 64'd1);
    check("sw_addr_n1", 64'(wb.wr_addr), 64'd10);
    check("sw_data_n1", 64'(wb.wr_data), 64'h6);
    check("sw_pend_n1", 64'(wb.pend_mask), 64'd0);
    tick();
    check("sw_regwr_n2", 64'(wb.reg_wr), 64'd0);

    // Same-edge collision to register 5
    wb.a_valid = 1'b1; wb.a_addr = 5'd5; wb.a_data = 32'h0000_0011;
    wb.b_valid = 1'b1; wb.b_addr = 5'd5; wb.b_data = 32'h0000_0022;
    tick();
    wb.a_valid = 1'b0;
    wb.b_valid = 1'b0;
    check("col_pend", 64'(wb.pend_mask), 64'h0000_0020);
    check("col_b_ready0", 64'(wb.b_ready), 64'd0);
    check("col_regwr0", 64'(wb.reg_wr), 64'd0);
    tick();
    check("col_regwr1", 64'(wb.reg_wr), 64'd1);
    check("col_addr1", 64'(wb.wr_addr), 64'd5);
    check("col_data1", 64'(wb.wr_data), 64'h11);
    check("col_b_ready1", 64'(wb.b_ready), 64'd0);
    tick();
    check("col_regwr2", 64'(wb.reg_wr), 64'd1);
    check("col_addr2", 64'(wb.wr_addr), 64'd5);
    check("col_data2", 64'(wb.wr_data), 64'h22);
    check("col_b_ready2", 64'(wb.b_ready), 64'd1);
    check("col_pend2", 64'(wb.pend_mask), 64'd0);
    tick();
    check("col_regwr3", 64'(wb.reg_wr), 64'd0);

    // Age priority: B accepted first, A one edge later
    wb.b_valid = 1'b1; wb.b_addr = 5'd7; wb.b_data = 32'h0000_000B;
    tick();
    wb.b_valid = 1'b0;
    wb.a_valid = 1'b1; wb.a_addr = 5'd8; wb.a_data = 32'h0000_000A;
    tick();
    wb.a_valid = 1'b0;
    check("age_regwr1", 64'(wb.reg_wr), 64'd1);
    check("age_addr1", 64'(wb.wr_addr), 64'd7);
    check("age_data1", 64'(wb.wr_data), 64'hB);
    check("age_pend1", 64'(wb.pend_mask), 64'h0000_0100);
    tick();
    check("age_regwr2", 64'(wb.reg_wr), 64'd1);
    check("age_addr2", 64'(wb.wr_addr), 64'd8);
    check("age_data2", 64'(wb.wr_data), 64'hA);
    tick();

    // Write to x0 completes the handshake but is dropped
    wb.a_valid = 1'b1; wb.a_addr = 5'd0; wb.a_data = 32'hFFFF_FFFF;
    check("x0_ready_pre", 64'(wb.a_ready), 64'd1);
    tick();
    wb.a_valid = 1'b0;
    check("x0_ready", 64'(wb.a_ready), 64'd1);
    check("x0_pend", 64'(wb.pend_mask), 64'd0);
    check("x0_regwr0", 64'(wb.reg_wr), 64'd0);
    tick();
    check("x0_regwr1", 64'(wb.reg_wr), 64'd0);
    check("x0_hold_data", 64'(wb.wr_data), 64'hA);
    check("x0_hold_addr", 64'(wb.wr_addr), 64'd8);

    // Streaming: both requesters continuously valid until 20 writes are accepted
    na = 0; nb = 0; run = 0; max_run = 0; retired = 0; prev_src = 0;
    for (int cyc = 0; cyc < 60 && ((na + nb) < 20 || expq.size() != 0); cyc++) begin
      wb.a_valid = ((na + nb) < 20);
      wb.a_addr  = 5'(1 + (na % 15));
      wb.a_data  = 32'h0000_1000 + 32'(na);
      acc_a      = wb.a_valid && wb.a_ready;
      wb.b_valid = ((na + nb + (acc_a ? 1 : 0)) < 20);
      wb.b_addr  = 5'(16 + (nb % 15));
      wb.b_data  = 32'h0000_2000 + 32'(nb);
      acc_b      = wb.b_valid && wb.b_ready;
      if (!wb.a_ready && !wb.b_ready) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (acc_a) begin expq.push_back(wb.a_data); na++; end
      if (acc_b) begin expq.push_back(wb.b_data); nb++; end
      tick();
      if (wb.reg_wr) begin
        retired++;
        if (expq.size() != 0) exp_word = expq.pop_front();
        else exp_word = 32'hDEAD_DEAD;
        check("str_data", 64'(wb.wr_data), 64'(exp_word));
        check("str_alternate", 64'(wb.wr_data[15:12] != prev_src[3:0]), 64'd1);
        prev_src = int'(wb.wr_data[15:12]);
      end
    end
    wb.a_valid = 1'b0;
    wb.b_valid = 1'b0;
    check("str_retired", 64'(retired), 64'd20);
    check("str_na", 64'(na), 64'd10);
    check("str_nb", 64'(nb), 64'd10);
    check("str_both_full", 64'(max_run <= 2), 64'd1);
    tick();
    check("str_idle", 64'(wb.reg_wr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: A (execute/ALU) and B (load/memory).
- Each requester gets a one-entry holding slot with a valid/ready handshake.
- Each cycle at most one held write is granted onto the registered write-port outputs (reg_wr, wr_addr, wr_data), which connect directly to the register file.
- Exports a pending-write mask so hazard logic can stall readers of registers with writes still in flight.

Parameters:
- XLEN, 32, data width of a write.
- AW, 5, register address width; register count = 2**AW.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- a_valid  in  1  requester A presents a write.
- a_ready  out  1  A slot can accept.
- a_addr  in  AW  A destination register.
- a_data  in  XLEN  A write data.
- b_valid  in  1  requester B presents a write.
- b_ready  out  1  B slot can accept.
- b_addr  in  AW  B destination register.
- b_data  in  XLEN  B write data.
- reg_wr  out  1  register-file write enable (registered).
- wr_addr  out  AW  register-file write address (registered).
- wr_data  out  XLEN  register-file write data (registered).
- pend_mask  out  2**AW  bit i = a write to register i is held in a slot.

Behaviour:
- Reset (rst=0 at a rising edge): both slots empty, age state cleared, reg_wr=0, wr_addr=0, wr_data=0.
  - While rst=0: a_ready=b_ready=0 and pend_mask=0.
  - Reset mid-operation discards held writes without emitting them.
- Ready: x_ready = rst & ~slot_x_full (combinational). A slot is never refilled on the edge it is granted; the earliest refill is the following edge.
- Accept: on an edge with x_valid & x_ready:
  - Latch addr/data and set slot_x_full.
  - If x_addr==0, the handshake completes but the write is dropped (slot stays empty; x0 is never written).
- Age: a 1-bit older flag records which full slot was accepted first.
  - If both slots are accepted on the same edge, A is older.
  - If one slot is accepted while the other is already full, the already-full slot is older.
- Grant (evaluated from slot state before the edge):
  - No slot full: reg_wr<=0; wr_addr/wr_data hold their previous values.
  - One slot full: grant it.
  - Both full: grant the older slot.
  - On grant: reg_wr<=1, wr_addr/wr_data<=slot contents, granted slot cleared.
  - reg_wr is a one-cycle pulse per granted write.
- Latency: accept at edge N -> reg_wr=1 in the cycle after edge N+1 at best; +1 edge if the other slot wins.
  - The register file samples on the falling edge, so the write lands mid-cycle.
- Ordering: same-address writes from A and B retire in acceptance order. Writes accepted on the same edge retire A then B; B's value is final.
- Throughput: one write per cycle peak. Neither requester starves: the empty-after-grant rule lets the other slot win the next edge.
- pend_mask: combinational OR of one-hot(slot_a_addr) gated by slot_a_full and one-hot(slot_b_addr) gated by slot_b_full. A granted entry's bit clears on the grant edge.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - Adds inputs rs1_addr, rs2_addr (AW) and outputs rs1_fwd_hit, rs2_fwd_hit (1) and rs1_fwd_data, rs2_fwd_data (XLEN).
  - A hit is combinational when the read address is non-zero and matches a full slot. On a hit, fwd_data returns that slot's data; if both slots match, the younger slot's data is returned.
  - With no hit, hit=0 and data=0.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles while a_valid=b_valid=1 -> a_ready=b_ready=0, reg_wr=0, pend_mask=0. Release -> both ready=1 on the next cycle.
- Single write: A sends addr=10, data=0x6 at edge N -> reg_wr=1, wr_addr=10, wr_data=0x6 for exactly one cycle after edge N+1. pend_mask[10]=1 only between edges N and N+1.
- Same-edge collision: A writes (5, 0x11) and B writes (5, 0x22) on the same edge -> two consecutive reg_wr pulses, 0x11 then 0x22, both to addr 5. b_ready=0 until B's grant edge.
- Age priority: B accepts (7, 0xB) at edge N, A accepts (8, 0xA) at edge N+1 -> B is granted at edge N+1 and A at edge N+2 (B older).
- x0 drop: A sends addr=0, data=0xFFFF_FFFF -> handshake completes, reg_wr stays 0, pend_mask stays 0, a_ready stays 1.
- Streaming: a_valid=b_valid=1 continuously with incrementing data for 20 cycles -> the reg_wr sequence alternates A/B, no cycle has both slots full for more than 2 cycles, and all 20 accepted writes appear in order.
